// File: rtl/brs_pkg.sv
// Shared types and constants for the brs_sched scheduler and its brs_log shifter.
package brs_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned CT_W   = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      RESP = 2'd2
   } state_t;

   // Sign-fill mask for an arithmetic right shift: top ct bits set, none for ct=0.
   function automatic logic [DATA_W-1:0] fill_mask(input logic [CT_W-1:0] ct);
      logic [DATA_W-1:0] ones;
      ones = '1;
      if (ct == '0) return '0;
      return ones << (DATA_W - 32'(ct));
   endfunction

endpackage

// File: rtl/brs_log.sv
// 3-level logarithmic logical right shifter (stages of 1, 2 and 4 bits).
module brs_log
   import brs_pkg::*;
(
   input  logic [DATA_W-1:0] inp_x,
   input  logic [CT_W-1:0]   shift_ct,
   output logic [DATA_W-1:0] outp_y
);

   logic [DATA_W-1:0] s1;
   logic [DATA_W-1:0] s2;

   always_comb begin
      s1     = shift_ct[0] ? (inp_x >> 1) : inp_x;
      s2     = shift_ct[1] ? (s1 >> 2)    : s1;
      outp_y = shift_ct[2] ? (s2 >> 4)    : s2;
   end

endmodule

// File: rtl/brs_sched.sv
// Round-robin two-requester scheduler sharing one brs_log shifter.
// Optional sign-fill (arithmetic shift) enabled by defining BRS_SCHED_ARITH_EN.
module brs_sched
   import brs_pkg::*;
#(
   parameter bit PRIO_INIT = 1'b0
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_x,
   input  logic [CT_W-1:0]   req0_ct,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_x,
   input  logic [CT_W-1:0]   req1_ct,
`ifdef BRS_SCHED_ARITH_EN
   input  logic              req0_arith,
   input  logic              req1_arith,
`endif
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_y,
   output logic              resp_id,
   output logic              busy
);

   state_t            state;
   state_t            state_nxt;
   logic              ptr;
   logic              grant;
   logic              win;
   logic [DATA_W-1:0] x_q;
   logic [CT_W-1:0]   ct_q;
   logic              id_q;
   logic [DATA_W-1:0] shift_y;
   logic [DATA_W-1:0] y_res;
`ifdef BRS_SCHED_ARITH_EN
   logic              arith_q;
`endif

   brs_log u_log (
      .inp_x    (x_q),
      .shift_ct (ct_q),
      .outp_y   (shift_y)
   );

`ifdef BRS_SCHED_ARITH_EN
   assign y_res = shift_y | ((arith_q && x_q[DATA_W-1]) ? fill_mask(ct_q) : '0);
`else
   assign y_res = shift_y;
`endif

   assign resp_valid = (state == RESP);
   assign busy       = (state != IDLE);

   // Grant is suppressed while reset is asserted so no request is acknowledged and then lost.
   always_comb begin
      state_nxt  = state;
      grant      = 1'b0;
      win        = ptr;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state)
         IDLE: begin
            if (rst_n && (req0_valid || req1_valid)) begin
               grant      = 1'b1;
               win        = (req0_valid && req1_valid) ? ptr : req1_valid;
               req0_ready = ~win;
               req1_ready = win;
               state_nxt  = EVAL;
            end
         end
         EVAL:    state_nxt = RESP;
         RESP:    if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         ptr     <= PRIO_INIT;
         x_q     <= '0;
         ct_q    <= '0;
         id_q    <= 1'b0;
         resp_y  <= '0;
         resp_id <= 1'b0;
`ifdef BRS_SCHED_ARITH_EN
         arith_q <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         if (grant) begin
            x_q  <= win ? req1_x  : req0_x;
            ct_q <= win ? req1_ct : req0_ct;
            id_q <= win;
            ptr  <= ~win;
`ifdef BRS_SCHED_ARITH_EN
            arith_q <= win ? req1_arith : req0_arith;
`endif
         end
         if (state == EVAL) begin
            resp_y  <= y_res;
            resp_id <= id_q;
         end
      end
   end

endmodule

// File: tb/tb_brs_sched.sv
// Self-checking bench for brs_sched; honours BRS_SCHED_ARITH_EN when defined.
`timescale 1ns/1ps
module tb_brs_sched;

`ifdef BRS_SCHED_ARITH_EN
   localparam bit ARITH = 1'b1;
`else
   localparam bit ARITH = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req0_valid = 1'b0, req1_valid = 1'b0;
   logic       req0_ready, req1_ready;
   logic [7:0] req0_x = '0, req1_x = '0;
   logic [2:0] req0_ct = '0, req1_ct = '0;
   logic       req0_arith = 1'b0, req1_arith = 1'b0;
   logic       resp_valid;
   logic       resp_ready = 1'b0;
   logic [7:0] resp_y;
   logic       resp_id;
   logic       busy;

   int vectors = 0;
   int miscompares = 0;
   logic ptr_m = 1'b0;
   logic served_id[$];
   logic [7:0] served_y[$];

   always #5 clk = ~clk;

   brs_sched #(.PRIO_INIT(1'b0)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_x     (req0_x),
      .req0_ct    (req0_ct),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_x     (req1_x),
      .req1_ct    (req1_ct),
`ifdef BRS_SCHED_ARITH_EN
      .req0_arith (req0_arith),
      .req1_arith (req1_arith),
`endif
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_y     (resp_y),
      .resp_id    (resp_id),
      .busy       (busy)
   );

   // Reference: plain right shift, or a signed shift when sign-fill is requested.
   function automatic logic [7:0] model_shift(input logic [7:0] x, input logic [2:0] ct, input logic ar);
      if (ar && x[7]) return 8'($signed(x) >>> ct);
      return x >> ct;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_arith = 1'b0; req1_arith = 1'b0;
      resp_ready = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      ptr_m = 1'b0;
   endtask

   // One isolated operation with resp_ready high; lat = edges from grant to resp_valid.
   task automatic do_op(input logic id, input logic [7:0] x, input logic [2:0] ct, input logic ar,
                        output logic [7:0] y, output logic rid, output int lat, output bit ok);
      bit got;
      got = 1'b0; ok = 1'b0; lat = 0; y = '0; rid = 1'b0;
      resp_ready = 1'b1;
      if (id) begin req1_valid = 1'b1; req1_x = x; req1_ct = ct; req1_arith = ar; end
      else    begin req0_valid = 1'b1; req0_x = x; req0_ct = ct; req0_arith = ar; end
      for (int i = 0; i < 10 && !got; i++) begin
         #1;
         if (id ? req1_ready : req0_ready) got = 1'b1;
         else step();
      end
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      for (int i = 1; i <= 10 && got && !ok; i++) begin
         if (resp_valid) begin ok = 1'b1; lat = i; y = resp_y; rid = resp_id; end
         else step();
      end
      step();
   endtask

   task automatic test_reset();
      apply_reset();
      rst_n = 1'b0;
      step();
      vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
      vectors++; if (resp_y !== 8'h00) begin miscompares++; $display("FAIL reset_resp_y got=%h exp=00", resp_y); end
      vectors++; if (resp_id !== 1'b0) begin miscompares++; $display("FAIL reset_resp_id got=%b exp=0", resp_id); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
      vectors++; if ({req0_ready, req1_ready} !== 2'b00) begin miscompares++; $display("FAIL reset_ready got=%b%b exp=00", req0_ready, req1_ready); end
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      apply_reset();
      resp_ready = 1'b1;
      req0_valid = 1'b1; req0_x = 8'hB4; req0_ct = 3'd3;
      #1;
      vectors++; if ({req0_ready, req1_ready} !== 2'b10) begin miscompares++; $display("FAIL single_grant got=%b%b exp=10", req0_ready, req1_ready); end
      vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL single_t0_valid got=%b exp=0", resp_valid); end
      step();
      req0_valid = 1'b0;
      vectors++; if ({resp_valid, busy} !== 2'b01) begin miscompares++; $display("FAIL single_t1 valid/busy got=%b%b exp=01", resp_valid, busy); end
      step();
      vectors++; if ({resp_valid, resp_id, resp_y} !== {1'b1, 1'b0, 8'h16}) begin
         miscompares++; $display("FAIL single_resp got v=%b id=%b y=%h exp v=1 id=0 y=16", resp_valid, resp_id, resp_y); end
      step();
      vectors++; if ({resp_valid, busy} !== 2'b00) begin miscompares++; $display("FAIL single_idle valid/busy got=%b%b exp=00", resp_valid, busy); end
      ptr_m = 1'b1;
   endtask

   // Cycle-level traffic against a transaction model: round-robin pointer, one op in flight.
   task automatic run_stream(input bit fixed, input int n_resp, input int max_cycles);
      logic [8:0] exp_q[$];
      bit outstanding;
      int age;
      int done;
      logic e0, e1, w;
      logic [8:0] head;
      outstanding = 1'b0; age = 0; done = 0;
      served_id.delete(); served_y.delete();
      for (int c = 0; c < max_cycles && done < n_resp; c++) begin
         resp_ready = fixed ? 1'b1 : 1'($urandom_range(0, 3) != 0);
         if (!req0_valid && (fixed || $urandom_range(0, 1) == 1)) begin
            req0_valid = 1'b1;
            req0_x = fixed ? 8'hF0 : 8'($urandom);
            req0_ct = fixed ? 3'd4 : 3'($urandom);
            req0_arith = fixed ? 1'b0 : (ARITH & 1'($urandom));
         end
         if (!req1_valid && (fixed || $urandom_range(0, 1) == 1)) begin
            req1_valid = 1'b1;
            req1_x = fixed ? 8'h81 : 8'($urandom);
            req1_ct = fixed ? 3'd1 : 3'($urandom);
            req1_arith = fixed ? 1'b0 : (ARITH & 1'($urandom));
         end
         if (outstanding) age++;
         #1;
         e0 = 1'b0; e1 = 1'b0; w = 1'b0;
         if (!outstanding && (req0_valid || req1_valid)) begin
            w = (req0_valid && req1_valid) ? ptr_m : req1_valid;
            e0 = ~w; e1 = w;
         end
         vectors++; if ({req0_ready, req1_ready} !== {e0, e1}) begin
            miscompares++; $display("FAIL stream_ready cyc=%0d got=%b%b exp=%b%b", c, req0_ready, req1_ready, e0, e1); end
         vectors++; if (resp_valid !== (outstanding && age >= 2)) begin
            miscompares++; $display("FAIL stream_resp_valid cyc=%0d got=%b exp=%b", c, resp_valid, (outstanding && age >= 2)); end
         vectors++; if (busy !== outstanding) begin
            miscompares++; $display("FAIL stream_busy cyc=%0d got=%b exp=%b", c, busy, outstanding); end
         if (outstanding && age >= 2) begin
            head = exp_q[0];
            vectors++; if ({resp_id, resp_y} !== head) begin
               miscompares++; $display("FAIL stream_resp cyc=%0d got id=%b y=%h exp id=%b y=%h", c, resp_id, resp_y, head[8], head[7:0]); end
            if (resp_ready) begin
               served_id.push_back(resp_id);
               served_y.push_back(resp_y);
               void'(exp_q.pop_front());
               outstanding = 1'b0;
               done++;
            end
         end
         if (e0 || e1) begin
            exp_q.push_back(w ? {1'b1, model_shift(req1_x, req1_ct, req1_arith)}
                              : {1'b0, model_shift(req0_x, req0_ct, req0_arith)});
            ptr_m = ~w;
            outstanding = 1'b1;
            age = 0;
         end
         step();
         if (e0) req0_valid = 1'b0;
         if (e1) req1_valid = 1'b0;
      end
      vectors++; if (done < n_resp) begin
         miscompares++; $display("FAIL stream_timeout got=%0d responses exp=%0d", done, n_resp); end
      req0_valid = 1'b0; req1_valid = 1'b0;
      resp_ready = 1'b1;
      step();
   endtask

   task automatic test_contention();
      apply_reset();
      run_stream(1'b1, 4, 40);
      for (int i = 0; i < 4; i++) begin
         if (i < served_id.size()) begin
            vectors++; if ({served_id[i], served_y[i]} !== ((i % 2 == 1) ? 9'h140 : 9'h00F)) begin
               miscompares++; $display("FAIL contention_order idx=%0d got id=%b y=%h exp id=%0d", i, served_id[i], served_y[i], i % 2); end
         end
      end
   endtask

   task automatic test_backpressure();
      apply_reset();
      resp_ready = 1'b0;
      req1_valid = 1'b1; req1_x = 8'h3C; req1_ct = 3'd2;
      #1;
      vectors++; if ({req0_ready, req1_ready} !== 2'b01) begin miscompares++; $display("FAIL bp_grant got=%b%b exp=01", req0_ready, req1_ready); end
      step();
      req1_valid = 1'b0;
      step();
      req0_valid = 1'b1; req0_x = 8'h11; req0_ct = 3'd1;
      req1_valid = 1'b1; req1_x = 8'h22; req1_ct = 3'd2;
      for (int i = 0; i < 3; i++) begin
         #1;
         vectors++; if ({resp_valid, busy, resp_id, resp_y} !== {1'b1, 1'b1, 1'b1, 8'h0F}) begin
            miscompares++; $display("FAIL bp_hold cyc=%0d got v=%b busy=%b id=%b y=%h exp v=1 busy=1 id=1 y=0f", i, resp_valid, busy, resp_id, resp_y); end
         vectors++; if ({req0_ready, req1_ready} !== 2'b00) begin
            miscompares++; $display("FAIL bp_no_grant cyc=%0d got=%b%b exp=00", i, req0_ready, req1_ready); end
         step();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      resp_ready = 1'b1;
      #1;
      vectors++; if (resp_valid !== 1'b1) begin miscompares++; $display("FAIL bp_release_valid got=%b exp=1", resp_valid); end
      step();
      vectors++; if ({resp_valid, busy} !== 2'b00) begin miscompares++; $display("FAIL bp_idle valid/busy got=%b%b exp=00", resp_valid, busy); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] y; logic rid; int lat; bit ok;
      apply_reset();
      do_op(1'b1, 8'hB4, 3'd3, 1'b0, y, rid, lat, ok);
      vectors++; if (!ok || y !== 8'h16 || rid !== 1'b1) begin
         miscompares++; $display("FAIL rmid_first got ok=%0d y=%h id=%b exp y=16 id=1", ok, y, rid); end
      req0_valid = 1'b1; req0_x = 8'hF0; req0_ct = 3'd4;
      #1;
      vectors++; if (req0_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_grant got=%b exp=1", req0_ready); end
      step();
      req0_valid = 1'b0;
      rst_n = 1'b0;
      step();
      vectors++; if ({resp_valid, busy, resp_y} !== {1'b0, 1'b0, 8'h00}) begin
         miscompares++; $display("FAIL rmid_reset got v=%b busy=%b y=%h exp v=0 busy=0 y=00", resp_valid, busy, resp_y); end
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_ghost cyc=%0d got=%b exp=0", i, resp_valid); end
      end
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      vectors++; if ({req0_ready, req1_ready} !== 2'b10) begin
         miscompares++; $display("FAIL rmid_ptr_restore got=%b%b exp=10", req0_ready, req1_ready); end
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      step(); step(); step();
   endtask

   task automatic test_boundaries();
      logic [7:0] xs[4];
      logic [2:0] cs[4];
      logic [7:0] y; logic rid; int lat; bit ok;
      xs = '{8'hA5, 8'h80, 8'hFF, 8'h01};
      cs = '{3'd0, 3'd7, 3'd7, 3'd1};
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         do_op(1'(i), xs[i], cs[i], 1'b0, y, rid, lat, ok);
         vectors++; if (!ok || y !== (xs[i] >> cs[i]) || rid !== 1'(i) || lat != 2) begin
            miscompares++; $display("FAIL boundary x=%h ct=%0d got ok=%0d y=%h id=%b lat=%0d exp y=%h id=%0d lat=2",
                                    xs[i], cs[i], ok, y, rid, lat, xs[i] >> cs[i], i % 2); end
      end
   endtask

`ifdef BRS_SCHED_ARITH_EN
   task automatic test_arith();
      logic [7:0] xs[4];
      logic [2:0] cs[4];
      logic [7:0] ex[4];
      logic [7:0] y; logic rid; int lat; bit ok;
      xs = '{8'h80, 8'h40, 8'hC0, 8'h90};
      cs = '{3'd7, 3'd2, 3'd0, 3'd3};
      ex = '{8'hFF, 8'h10, 8'hC0, 8'hF2};
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         do_op(1'b0, xs[i], cs[i], 1'b1, y, rid, lat, ok);
         vectors++; if (!ok || y !== ex[i]) begin
            miscompares++; $display("FAIL arith x=%h ct=%0d got ok=%0d y=%h exp y=%h", xs[i], cs[i], ok, y, ex[i]); end
      end
      req0_arith = 1'b0;
   endtask
`endif

   task automatic test_random();
      apply_reset();
      run_stream(1'b0, 40, 2000);
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_reset_mid();
      test_boundaries();
`ifdef BRS_SCHED_ARITH_EN
      test_arith();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
